// File: rtl/velocity_cordic.sv
// Speed/angle to {vx, vy} velocity decomposer: iterative CORDIC rotation of (v, 0)
// through the residual angle, gain correction, then a quadrant fold and optional x-reflection.
module velocity_cordic #(
  parameter int W    = 16,
  parameter int FRAC = 4,
  parameter int AW   = 16,
  parameter int ITER = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    ball_velocity,
  input  logic [AW-1:0]   ball_angle,
  input  logic            reflect_x,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  ball_velocity_modified
);

  localparam int XW = W + 2;
  localparam int ZW = AW - 2;
  localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int MW = XW + 17;
  // atan table is held at 2^24 units per 90 degrees and rounded down to 2^(AW-4).
  localparam int SH = 28 - AW;
  localparam logic [31:0] RND = 32'd1 << (SH - 1);
  localparam logic signed [16:0] K = 17'sd39797;
  localparam logic signed [MW-1:0] K_HALF = MW'(32768);
  localparam logic [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] S_MAX = {1'b0, {(W-1){1'b1}}};

  if (ITER < 4 || ITER > AW - 4 || AW > 24 || FRAC < 0 || FRAC >= W) begin : g_param_err
    $error("velocity_cordic: unsupported parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_ROT, S_SCALE, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic signed [XW-1:0]   x_q, x_d, y_q, y_d;
  logic signed [ZW-1:0]   z_q, z_d;
  logic [IW-1:0]          iter_q, iter_d;
  logic [1:0]             quad_q, quad_d;
  logic                   refl_q, refl_d;
  logic [2*W-1:0]         res_q, res_d;

  logic signed [XW-1:0]   xs, ys;
  logic signed [ZW-1:0]   at;
  logic [W-1:0]           c, s, vx, vy;
  logic                   unused_angle_top;

  assign unused_angle_top = ^ball_angle[AW-1:AW-2];

  function automatic logic signed [ZW-1:0] atan_of(input int i);
    logic [31:0] t;
    case (i)
      0:  t = 32'd8388608;
      1:  t = 32'd4952084;
      2:  t = 32'd2616545;
      3:  t = 32'd1328199;
      4:  t = 32'd666677;
      5:  t = 32'd333663;
      6:  t = 32'd166872;
      7:  t = 32'd83441;
      8:  t = 32'd41721;
      9:  t = 32'd20861;
      10: t = 32'd10430;
      11: t = 32'd5215;
      12: t = 32'd2608;
      13: t = 32'd1304;
      14: t = 32'd652;
      15: t = 32'd326;
      16: t = 32'd163;
      17: t = 32'd81;
      18: t = 32'd41;
      19: t = 32'd20;
      20: t = 32'd10;
      default: t = 32'd0;
    endcase
    t = (t + RND) >> SH;
    return t[ZW-1:0];
  endfunction

  // Gain correction by K/2^16 with round-half-up, clamped to the W-bit range.
  function automatic logic [W-1:0] scale_sat(input logic signed [XW-1:0] a);
    logic signed [MW-1:0] p;
    logic [MW-W:0]        hi;
    p  = MW'(a) * MW'(K);
    p  = (p + K_HALF) >>> 16;
    hi = p[MW-1:W-1];
    if (&hi || !(|hi)) return p[W-1:0];
    return p[MW-1] ? S_MIN : S_MAX;
  endfunction

  function automatic logic [W-1:0] neg_sat(input logic [W-1:0] a);
    if (a == S_MIN) return S_MAX;
    return -a;
  endfunction

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    iter_d  = iter_q;
    quad_d  = quad_q;
    refl_d  = refl_q;
    res_d   = res_q;
    xs      = x_q >>> iter_q;
    ys      = y_q >>> iter_q;
    at      = atan_of(int'(iter_q));
    c       = scale_sat(x_q);
    s       = scale_sat(y_q);
    vx      = '0;
    vy      = '0;

    case (quad_q)
      2'd0:    begin vx = s;          vy = c;          end
      2'd1:    begin vx = c;          vy = neg_sat(s); end
      2'd2:    begin vx = neg_sat(s); vy = neg_sat(c); end
      default: begin vx = neg_sat(c); vy = s;          end
    endcase
    if (refl_q) vx = neg_sat(vx);

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d     = {{2{ball_velocity[W-1]}}, ball_velocity};
          y_d     = '0;
          z_d     = {2'b00, ball_angle[AW-5:0]};
          iter_d  = '0;
          quad_d  = ball_angle[AW-3:AW-4];
          refl_d  = reflect_x;
          state_d = S_ROT;
        end
      end
      S_ROT: begin
        // z >= 0 rotates counter-clockwise; zero counts as positive so every step rotates.
        if (!z_q[ZW-1]) begin
          x_d = x_q - ys;
          y_d = y_q + xs;
          z_d = z_q - at;
        end else begin
          x_d = x_q + ys;
          y_d = y_q - xs;
          z_d = z_q + at;
        end
        if (iter_q == IW'(ITER - 1)) begin
          iter_d  = '0;
          state_d = S_SCALE;
        end else begin
          iter_d = iter_q + 1'b1;
        end
      end
      S_SCALE: begin
        res_d   = {vx, vy};
        state_d = S_DONE;
      end
      default: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      iter_q  <= '0;
      quad_q  <= '0;
      refl_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      iter_q  <= iter_d;
      quad_q  <= quad_d;
      refl_q  <= refl_d;
      res_q   <= res_d;
    end
  end

  assign in_ready               = (state_q == S_IDLE);
  assign out_valid              = (state_q == S_DONE);
  assign ball_velocity_modified = res_q;

endmodule

// File: tb/tb_velocity_cordic.sv
// Directed bench for velocity_cordic: angle/quadrant vectors, reflection, saturation,
// latency, backpressure and mid-rotation reset.
module tb_velocity_cordic;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, reflect_x, out_valid, out_ready;
  logic [15:0] ball_velocity, ball_angle;
  logic [31:0] ball_velocity_modified;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] v;
    logic [15:0] ang;
    logic        refl;
    int          evx;
    int          evy;
    int          tol_x;
    int          tol_y;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  velocity_cordic #(.W(16), .FRAC(4), .AW(16), .ITER(12)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .in_valid               (in_valid),
    .in_ready               (in_ready),
    .ball_velocity          (ball_velocity),
    .ball_angle             (ball_angle),
    .reflect_x              (reflect_x),
    .out_valid              (out_valid),
    .out_ready              (out_ready),
    .ball_velocity_modified (ball_velocity_modified)
  );

  task automatic chk(input string tag, input int obs, input int exp, input int tol);
    int diff;
    n_chk++;
    diff = obs - exp;
    if (diff > tol || diff < -tol) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic int vx_now();
    return int'($signed(ball_velocity_modified[31:16]));
  endfunction

  function automatic int vy_now();
    return int'($signed(ball_velocity_modified[15:0]));
  endfunction

  // Starts and ends #1 after a rising edge. Inputs are scrambled right after the
  // accept edge; with poke set, in_valid stays high with other data while busy.
  task automatic do_req(input logic [15:0] v, input logic [15:0] ang, input logic refl,
                        input logic poke, output int lat);
    ball_velocity = v;
    ball_angle    = ang;
    reflect_x     = refl;
    in_valid      = 1'b1;
    @(posedge clk); #1;
    ball_velocity = 16'h7000;
    ball_angle    = 16'h3AAA;
    reflect_x     = ~refl;
    in_valid      = poke;
    lat = 0;
    while (!out_valid && lat < 100) begin
      chk("busy_in_ready", int'(in_ready), 0, 0);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_xfer_in_ready", int'(in_ready), 1, 0);
    chk("post_xfer_out_valid", int'(out_valid), 0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int seen;

    vecs[0] = '{16'h00F0, 16'h0000, 1'b0,    0,   240,  1, 1};
    vecs[1] = '{16'h00F0, 16'h1000, 1'b0,  240,     0,  1, 1};
    vecs[2] = '{16'h00F0, 16'h0555, 1'b0,  120,   208,  1, 1};
    vecs[3] = '{16'h00F0, 16'h0AAA, 1'b0,  208,   120,  1, 1};
    vecs[4] = '{16'h00F0, 16'h0555, 1'b1, -120,   208,  1, 1};
    vecs[5] = '{16'h00F0, 16'h2555, 1'b0, -120,  -208,  1, 1};
    vecs[6] = '{16'h00F0, 16'h3555, 1'b0, -208,   120,  1, 1};
    vecs[7] = '{16'h00F0, 16'hC555, 1'b0,  120,   208,  1, 1};
    // Full-scale speed: one angle LSB of table rounding is ~12 output LSBs of vx.
    vecs[8] = '{16'h8000, 16'h2000, 1'b0,    0, 32767, 16, 0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; reflect_x = 1'b0;
    ball_velocity = '0; ball_angle = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", int'(in_ready), 1, 0);
    chk("rst_out_valid", int'(out_valid), 0, 0);
    chk("rst_output", int'(ball_velocity_modified), 0, 0);

    for (int k = 0; k < 9; k++) begin
      do_req(vecs[k].v, vecs[k].ang, vecs[k].refl, 1'b0, lat);
      chk($sformatf("v%0d_latency", k), lat, 13, 0);
      chk($sformatf("v%0d_vx", k), vx_now(), vecs[k].evx, vecs[k].tol_x);
      chk($sformatf("v%0d_vy", k), vy_now(), vecs[k].evy, vecs[k].tol_y);
      consume();
    end

    // Backpressure: busy-time requests ignored, result held for 20 cycles.
    do_req(16'h00F0, 16'h0555, 1'b0, 1'b1, lat);
    chk("bp_latency", lat, 13, 0);
    repeat (20) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", int'(out_valid), 1, 0);
      chk("bp_hold_in_ready", int'(in_ready), 0, 0);
      chk("bp_hold_vx", vx_now(), 120, 1);
      chk("bp_hold_vy", vy_now(), 208, 1);
    end
    consume();

    // out_ready already high: transfer completes on the first DONE cycle.
    out_ready = 1'b1;
    do_req(16'h00F0, 16'h0AAA, 1'b0, 1'b0, lat);
    chk("early_rdy_latency", lat, 13, 0);
    chk("early_rdy_vx", vx_now(), 208, 1);
    chk("early_rdy_vy", vy_now(), 120, 1);
    @(posedge clk); #1;
    chk("early_rdy_in_ready", int'(in_ready), 1, 0);
    chk("early_rdy_out_valid", int'(out_valid), 0, 0);
    out_ready = 1'b0;

    // Reset during ROT discards the request and clears the held result.
    ball_velocity = 16'h00F0; ball_angle = 16'h0555; reflect_x = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("rot_in_ready", int'(in_ready), 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready", int'(in_ready), 1, 0);
    chk("midrst_out_valid", int'(out_valid), 0, 0);
    chk("midrst_output", int'(ball_velocity_modified), 0, 0);
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("midrst_no_out_valid", seen, 0, 0);

    do_req(16'h00F0, 16'h0555, 1'b1, 1'b0, lat);
    chk("recover_latency", lat, 13, 0);
    chk("recover_vx", vx_now(), -120, 1);
    chk("recover_vy", vy_now(), 208, 1);
    consume();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
